// File: rtl/remap_pipe_pkg.sv
// Shared defines for the remap (approximate log2) datapath: default widths and
// the mode encoding carried alongside each operand.
package remap_pipe_pkg;

  localparam int NUM_LENGTH_DEF = 32;
  localparam int M_LENGTH_DEF   = 8;
  localparam int K_LENGTH_DEF   = $clog2(NUM_LENGTH_DEF);

  typedef enum logic {
    MODE_PLAIN = 1'b0,
    MODE_CORR  = 1'b1
  } remap_mode_e;

endpackage

// File: rtl/remap_corr.sv
// Mantissa remap: passes the Mitchell fraction through, or adds a parabolic
// correction term m1*(1-m1) scaled by 1/4 + 1/16, saturated to the field width.
module remap_corr
  import remap_pipe_pkg::*;
#(
  parameter int M_LENGTH = M_LENGTH_DEF
) (
  input  logic [M_LENGTH-1:0] m1,
  input  remap_mode_e         mode,
  output logic [M_LENGTH-1:0] m2
);

  localparam logic [M_LENGTH-1:0] M_MAX = '1;

  function automatic logic [M_LENGTH-1:0] sat_m(input logic [M_LENGTH+1:0] v);
    return (v > {2'b00, M_MAX}) ? M_MAX : v[M_LENGTH-1:0];
  endfunction

  logic [2*M_LENGTH-1:0] prod;
  logic [M_LENGTH-1:0]   c;
  logic [M_LENGTH+1:0]   sum;

  always_comb begin
    prod = {{M_LENGTH{1'b0}}, m1} * {{M_LENGTH{1'b0}}, M_MAX - m1};
    c    = M_LENGTH'(prod >> M_LENGTH);
    sum  = {2'b00, m1} + {2'b00, c >> 2} + {2'b00, c >> 4};
    m2   = (mode == MODE_CORR) ? sat_m(sum) : m1;
  end

endmodule

// File: rtl/remap_pipe.sv
// Three-stage approximate log2: leading-one detect, normalise shift, mantissa
// remap. A single global stall freezes every stage while the output is blocked.
module remap_pipe
  import remap_pipe_pkg::*;
#(
  parameter int NUM_LENGTH = NUM_LENGTH_DEF,
  parameter int M_LENGTH   = M_LENGTH_DEF,
  parameter int K_LENGTH   = $clog2(NUM_LENGTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [NUM_LENGTH-1:0]        num_i,
  input  logic                         mode_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [K_LENGTH+M_LENGTH-1:0] rslt_o,
  output logic                         zero_o
);

  localparam logic [K_LENGTH-1:0] K_MAX = K_LENGTH'(NUM_LENGTH - 1);

  logic adv;
  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;

  // S1: leading-one detect on the incoming operand
  logic [K_LENGTH-1:0] k_lod;
  logic                zero_lod;

  always_comb begin
    k_lod = '0;
    for (int i = 0; i < NUM_LENGTH; i++) begin
      if (num_i[i]) k_lod = K_LENGTH'(i);
    end
    zero_lod = (num_i == '0);
  end

  logic                  vld_p0;
  logic [NUM_LENGTH-1:0] num_p0;
  logic [K_LENGTH-1:0]   k_p0;
  remap_mode_e           mode_p0;
  logic                  zero_p0;

  always_ff @(posedge clk_i) begin
    if (adv && valid_i) begin
      num_p0  <= num_i;
      k_p0    <= k_lod;
      mode_p0 <= remap_mode_e'(mode_i);
      zero_p0 <= zero_lod;
    end
  end

  // S2: shift the leading one to the top; the field below it is the fraction
  logic [K_LENGTH-1:0]            shamt;
  logic [NUM_LENGTH+M_LENGTH-1:0] norm;
  logic [M_LENGTH-1:0]            m1_norm;

  always_comb begin
    shamt   = K_MAX - k_p0;
    norm    = {num_p0, {M_LENGTH{1'b0}}} << shamt;
    m1_norm = M_LENGTH'(norm >> (NUM_LENGTH - 1));
  end

  logic                vld_p1;
  logic [K_LENGTH-1:0] k_p1;
  logic [M_LENGTH-1:0] m1_p1;
  remap_mode_e         mode_p1;
  logic                zero_p1;

  always_ff @(posedge clk_i) begin
    if (adv && vld_p0) begin
      k_p1    <= k_p0;
      m1_p1   <= m1_norm;
      mode_p1 <= mode_p0;
      zero_p1 <= zero_p0;
    end
  end

  // S3: mantissa remap into the output register
  logic [M_LENGTH-1:0] m2_s3;

  remap_corr #(
    .M_LENGTH(M_LENGTH)
  ) u_corr (
    .m1  (m1_p1),
    .mode(mode_p1),
    .m2  (m2_s3)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      valid_o <= 1'b0;
      rslt_o  <= '0;
      zero_o  <= 1'b0;
    end else if (adv) begin
      vld_p0  <= valid_i;
      vld_p1  <= vld_p0;
      valid_o <= vld_p1;
      if (vld_p1) begin
        rslt_o <= zero_p1 ? '0 : {k_p1, m2_s3};
        zero_o <= zero_p1;
      end
    end
  end

endmodule

// File: doc/remap_pipe.md
REMAP_PIPE -- requirements
Module: remap_pipe

Interface
REQ-001 Parameter NUM_LENGTH, default 32, input operand width (power of two, 8..64).
REQ-002 Parameter M_LENGTH, default 8, fractional (mantissa) width of result.
REQ-003 Parameter K_LENGTH, default $clog2(NUM_LENGTH), integer (key) width of result; not overridden by instantiator.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-006 valid_i  input  1  num_i/mode_i qualify this cycle.
REQ-007 ready_o  output  1  block accepts input when high.
REQ-008 num_i  input  NUM_LENGTH  unsigned operand.
REQ-009 mode_i  input  1  0 = plain remap (Mitchell), 1 = corrected remap.
REQ-010 valid_o  output  1  rslt_o/zero_o valid.
REQ-011 ready_i  input  1  downstream accepts output.
REQ-012 rslt_o  output  K_LENGTH+M_LENGTH  {k, m2}, fixed-point approximate log2(num_i).
REQ-013 zero_o  output  1  operand was zero; rslt_o is 0.

Function
REQ-014 Transfer in: valid_i && ready_o; transfer out: valid_o && ready_i.
REQ-015 Three pipeline stages: S1 leading-one detect (k), S2 normalise shift (m1), S3 remap (m2); latency exactly 3 cycles from accept to valid_o with ready_i held high.
REQ-016 Global stall: ready_o = !valid_o || ready_i; when ready_o is low no stage register changes.
REQ-017 Full throughput: one result per cycle while ready_i is high; no bubbles inserted.
REQ-018 k = index of most-significant set bit of num_i (0..NUM_LENGTH-1).
REQ-019 m1 = bits below the leading one, left-aligned into M_LENGTH bits; truncated (no rounding) if k > M_LENGTH, zero-padded at LSB if k < M_LENGTH.
REQ-020 Mode 0: m2 = m1.
REQ-021 Mode 1: c = (m1 * (2^M_LENGTH-1-m1)) >> M_LENGTH; m2 = m1 + (c>>2) + (c>>4), saturated to 2^M_LENGTH-1.
REQ-022 mode_i is sampled with its operand and travels with it; mode changes between consecutive operands take effect per-operand.
REQ-023 num_i == 0: k = 0, m2 = 0, zero_o = 1; otherwise zero_o = 0.
REQ-024 valid_o, rslt_o, zero_o held stable while valid_o && !ready_i.
REQ-025 Output registers update only on a stage advance; rslt_o is undefined-free (registered) at all times.

Reset
REQ-026 rst_i asserted: all stage valid bits, valid_o, rslt_o, zero_o clear to 0 immediately, without waiting for a clock edge.
REQ-027 Reset mid-operation discards all in-flight operands; none emerge after deassertion.
REQ-028 ready_o = 1 during and after reset (pipeline empty).
REQ-029 First accept possible on the first rising edge after rst_i deasserts.

Structure
REQ-030 NUM_LENGTH, M_LENGTH, K_LENGTH defaults and the mode encoding (MODE_PLAIN=0, MODE_CORR=1) live in the shared defines package used by the existing combinational remap datapath.
REQ-031 One sub-module: remap_corr (combinational, M_LENGTH-parameterised, m1+mode -> m2, implementing REQ-020/021); LOD and shifter remain inline per stage.
REQ-032 Single clock domain; no multicycle paths; multiplier in S3 only.

Verification (defaults 32/8/5)
REQ-033 num=0x00000006, mode=0 -> after 3 cycles rslt_o=0x280, zero_o=0; mode=1 -> rslt_o=0x292.
REQ-034 num=0x00000001 -> 0x000, zero_o=0; num=0x00000000 -> 0x000, zero_o=1; num=0x80000000 -> 0x1F00.
REQ-035 num=0xFFFFFFFF, mode=1 -> 0x1FFF (c=0, no overflow); sweep of all m1 in mode 1 never wraps (saturation check).
REQ-036 Back-to-back 8 operands with ready_i=1 -> 8 results on 8 consecutive cycles, in order, modes alternating per operand.
REQ-037 ready_i low for 4 cycles with pipeline full -> ready_o=0, rslt_o stable, no loss or duplication on release.
REQ-038 rst_i pulse between clock edges with 3 operands in flight -> valid_o=0 immediately, no stale outputs after release, ready_o=1.
